// File: rtl/xor_pkg.sv
// Shared encodings for the streaming XOR checksum engine: FSM state codes
// and the generate/check mode values.
package xor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic MODE_GEN   = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

endpackage

// File: rtl/xor_reduce.sv
// Combinational XOR-reduction of one word; yields the parity of the final
// checksum as it is loaded into the result registers.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  output logic             parity
);

  assign parity = ^word;

endmodule

// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum engine: folds one WIDTH-bit word per clock into a
// running checksum and presents the frame result under a valid/ready handshake.
module xor_checksum_unit
  import xor_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               MAX_WORDS = 16,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
  localparam int              CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  input  logic             MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_SUM,
  output logic             OUT_PARITY,
  output logic             OUT_ERR,
  output logic             OUT_OVF,
  output logic [CW-1:0]    OUT_COUNT
);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             mode_q;

  logic             accept;
  logic             first_word;
  logic             at_limit;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    count_next;
  logic             ovf_next;
  logic             mode_next;
  logic             parity_next;

  assign IN_READY   = (state != ST_HOLD);
  assign accept     = IN_VALID & IN_READY;
  assign first_word = (state == ST_IDLE);
  assign at_limit   = (count == CW'(MAX_WORDS));

  // The first word of a frame starts from the seed, so nothing left in acc,
  // count or ovf from an earlier (or aborted) frame can leak into this one.
  assign acc_next   = (first_word ? INIT : acc) ^ IN_DATA;
  assign count_next = first_word ? CW'(1) : (at_limit ? count : count + CW'(1));
  assign ovf_next   = first_word ? 1'b0 : (ovf | at_limit);
  assign mode_next  = first_word ? MODE : mode_q;

  xor_reduce #(.WIDTH(WIDTH)) u_reduce (
    .word   (acc_next),
    .parity (parity_next)
  );

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      acc    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      mode_q <= MODE_GEN;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc    <= acc_next;
            count  <= count_next;
            ovf    <= ovf_next;
            mode_q <= mode_next;
            state  <= IN_LAST ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (OUT_VALID && OUT_READY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result registers load on the edge that accepts LAST, using the
  // next-state values so the last word is already folded in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID  <= 1'b0;
      OUT_SUM    <= '0;
      OUT_PARITY <= 1'b0;
      OUT_ERR    <= 1'b0;
      OUT_OVF    <= 1'b0;
      OUT_COUNT  <= '0;
    end else if (accept && IN_LAST) begin
      OUT_VALID  <= 1'b1;
      OUT_SUM    <= acc_next;
      OUT_PARITY <= parity_next;
      OUT_ERR    <= (mode_next == MODE_CHECK) && (acc_next != '0);
      OUT_OVF    <= ovf_next;
      OUT_COUNT  <= count_next;
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Bench for xor_checksum_unit: two instances (INIT 0x00 and 0x5A) share one
// directed stimulus stream; a frame-level model is compared every cycle.
module tb_xor_checksum_unit;

  localparam int          MAXW  = 4;
  localparam logic [15:0] INITS = 16'h5A00;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_LAST = 1'b0;
  logic       MODE = 1'b0;
  logic       OUT_READY = 1'b1;

  logic [1:0] in_ready;
  logic [1:0] out_valid;
  logic [1:0] out_parity;
  logic [1:0] out_err;
  logic [1:0] out_ovf;
  logic [7:0] out_sum   [2];
  logic [2:0] out_count [2];

  int checks = 0;
  int errors = 0;
  int ready_low_total = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    xor_checksum_unit #(
      .WIDTH     (8),
      .MAX_WORDS (MAXW),
      .INIT      (INITS[g*8 +: 8])
    ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IN_VALID   (IN_VALID),
      .IN_READY   (in_ready[g]),
      .IN_DATA    (IN_DATA),
      .IN_LAST    (IN_LAST),
      .MODE       (MODE),
      .OUT_VALID  (out_valid[g]),
      .OUT_READY  (OUT_READY),
      .OUT_SUM    (out_sum[g]),
      .OUT_PARITY (out_parity[g]),
      .OUT_ERR    (out_err[g]),
      .OUT_OVF    (out_ovf[g]),
      .OUT_COUNT  (out_count[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the list of accepted words; its result is
  // the seed XOR all words, counted and flagged by plain arithmetic.
  bit       m_hold [2];
  int       m_n    [2];
  bit [7:0] m_x    [2];
  bit       m_mode [2];
  bit       e_valid[2];
  bit [7:0] e_sum  [2];
  bit       e_par  [2];
  bit       e_err  [2];
  bit       e_ovf  [2];
  bit [2:0] e_cnt  [2];

  always @(posedge CLK or posedge RST) begin
    for (int g = 0; g < 2; g++) begin
      if (RST) begin
        m_hold[g]  <= 1'b0;
        m_n[g]     <= 0;
        m_x[g]     <= '0;
        m_mode[g]  <= 1'b0;
        e_valid[g] <= 1'b0;
        e_sum[g]   <= '0;
        e_par[g]   <= 1'b0;
        e_err[g]   <= 1'b0;
        e_ovf[g]   <= 1'b0;
        e_cnt[g]   <= '0;
      end else begin
        if (m_hold[g] && OUT_READY) begin
          m_hold[g]  <= 1'b0;
          e_valid[g] <= 1'b0;
        end
        if (IN_VALID && !m_hold[g]) begin
          automatic bit [7:0] x = (m_n[g] == 0) ? INITS[g*8 +: 8] : m_x[g];
          automatic bit       md = (m_n[g] == 0) ? MODE : m_mode[g];
          automatic int       n = m_n[g] + 1;
          x = x ^ IN_DATA;
          m_x[g]    <= x;
          m_mode[g] <= md;
          m_n[g]    <= n;
          if (IN_LAST) begin
            e_sum[g]   <= x;
            e_par[g]   <= ^x;
            e_err[g]   <= md && (x != 8'h00);
            e_ovf[g]   <= (n > MAXW);
            e_cnt[g]   <= 3'((n > MAXW) ? MAXW : n);
            e_valid[g] <= 1'b1;
            m_hold[g]  <= 1'b1;
            m_n[g]     <= 0;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!in_ready[0]) ready_low_total <= ready_low_total + 1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("in_ready[%0d]", g),   32'(in_ready[g]),   32'(!m_hold[g]));
      check($sformatf("out_valid[%0d]", g),  32'(out_valid[g]),  32'(e_valid[g]));
      check($sformatf("out_sum[%0d]", g),    32'(out_sum[g]),    32'(e_sum[g]));
      check($sformatf("out_parity[%0d]", g), 32'(out_parity[g]), 32'(e_par[g]));
      check($sformatf("out_err[%0d]", g),    32'(out_err[g]),    32'(e_err[g]));
      check($sformatf("out_ovf[%0d]", g),    32'(out_ovf[g]),    32'(e_ovf[g]));
      check($sformatf("out_count[%0d]", g),  32'(out_count[g]),  32'(e_cnt[g]));
    end
  end

  // Drive one word and hold it until the DUT accepts it (bounded wait).
  task automatic send_word(input logic [7:0] d, input logic last, input logic md);
    int  budget = 0;
    bit  done = 0;
    logic rdy;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    IN_LAST  = last;
    MODE     = md;
    while (!done) begin
      @(negedge CLK);
      rdy = in_ready[0];
      @(posedge CLK);
      #1;
      if (rdy) done = 1;
      else if (++budget > 50) begin
        check("send_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
  endtask

  // Hand-computed result for the frame whose LAST was just accepted; sampled
  // in the cycle right after that edge, which also pins the latency.
  task automatic expect_res(input string name, input logic [7:0] sum, input logic par,
                            input logic err, input logic ovf, input logic [2:0] cnt,
                            input logic [7:0] sum1);
    @(negedge CLK);
    check({name, "_valid"},  32'(out_valid[0]),  32'd1);
    check({name, "_sum"},    32'(out_sum[0]),    32'(sum));
    check({name, "_parity"}, 32'(out_parity[0]), 32'(par));
    check({name, "_err"},    32'(out_err[0]),    32'(err));
    check({name, "_ovf"},    32'(out_ovf[0]),    32'(ovf));
    check({name, "_count"},  32'(out_count[0]),  32'(cnt));
    check({name, "_sum_init5a"}, 32'(out_sum[1]), 32'(sum1));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int rl0;
    repeat (2) @(negedge CLK);
    check("rst_valid", 32'(out_valid[0]), 32'd0);
    check("rst_sum",   32'(out_sum[0]),   32'd0);
    check("rst_count", 32'(out_count[0]), 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_release_ready", 32'(in_ready[0]), 32'd1);
    @(posedge CLK);
    #1;

    // Generate mode
    send_word(8'h12, 0, 0);
    send_word(8'h34, 0, 0);
    send_word(8'h56, 1, 0);
    expect_res("gen", 8'h70, 1, 0, 0, 3'd3, 8'h2A);

    // Check mode, good and corrupted checksum word
    send_word(8'h12, 0, 1);
    send_word(8'h34, 0, 1);
    send_word(8'h56, 0, 1);
    send_word(8'h70, 1, 1);
    expect_res("chk_ok", 8'h00, 0, 0, 0, 3'd4, 8'h5A);
    send_word(8'h12, 0, 1);
    send_word(8'h34, 0, 1);
    send_word(8'h56, 0, 1);
    send_word(8'h71, 1, 1);
    expect_res("chk_bad", 8'h01, 1, 1, 0, 3'd4, 8'h5B);

    // Single-word frame held by a stalled consumer
    OUT_READY = 1'b0;
    send_word(8'hA5, 1, 0);
    IN_VALID = 1'b1;
    IN_DATA  = 8'hFF;
    IN_LAST  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_valid", 32'(out_valid[0]), 32'd1);
      check("hold_ready", 32'(in_ready[0]),  32'd0);
      check("hold_sum",   32'(out_sum[0]),   32'hA5);
      check("hold_sum_init5a", 32'(out_sum[1]), 32'hFF);
      @(posedge CLK);
      #1;
    end
    IN_VALID  = 1'b0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("release_valid", 32'(out_valid[0]), 32'd0);
    check("release_ready", 32'(in_ready[0]),  32'd1);
    check("release_sum_kept", 32'(out_sum[0]), 32'hA5);
    @(posedge CLK);
    #1;

    // Overflow: six words, counter saturates at MAXW
    for (int i = 0; i < 6; i++) send_word(8'h01, (i == 5), 0);
    expect_res("ovf", 8'h00, 0, 0, 1, 3'd4, 8'h5A);

    // Reset in the middle of a frame
    send_word(8'h11, 0, 0);
    send_word(8'h22, 0, 0);
    #2 RST = 1'b1;
    #1;
    check("midrst_valid",  32'(out_valid[0]), 32'd0);
    check("midrst_ovf",    32'(out_ovf[0]),   32'd0);
    check("midrst_count",  32'(out_count[0]), 32'd0);
    check("midrst_sum1",   32'(out_sum[1]),   32'd0);
    check("midrst_ready",  32'(in_ready[0]),  32'd1);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    send_word(8'hFF, 1, 0);
    expect_res("post_rst", 8'hFF, 0, 0, 0, 3'd1, 8'hA5);

    // Back-to-back two-word frames with IN_VALID and OUT_READY held high
    rl0 = ready_low_total;
    send_word(8'h01, 0, 0);
    send_word(8'h02, 1, 0);
    send_word(8'h03, 0, 0);
    send_word(8'h04, 1, 0);
    check("b2b_ready_low_cycles", 32'(ready_low_total - rl0), 32'd1);
    expect_res("b2b_second", 8'h07, 1, 0, 0, 3'd2, 8'h5D);

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xor_checksum_unit.md
# xor_checksum_unit

Streaming XOR checksum engine, the parametrised successor to the single-bit XOR gate. It folds a frame of WIDTH-bit words into one WIDTH-bit XOR checksum, one word per clock, under a valid/ready handshake. In generate mode it produces the checksum to append to a frame. In check mode it verifies a frame whose last word is that checksum. It sits between a word source and a framing/transmit or receive-error stage.

## Interface
Parameters:
- WIDTH, 8: data/checksum word width in bits; must be at least 1.
- MAX_WORDS, 16: frame length limit; the word counter saturates here.
- INIT, {WIDTH{1'b0}}: seed XORed into every frame's checksum.

Ports (CW = $clog2(MAX_WORDS+1)):
- CLK  in  1  rising-edge clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  input word present.
- IN_READY  out  1  unit accepts a word this cycle.
- IN_DATA  in  WIDTH  input word.
- IN_LAST  in  1  marks the final word of the frame.
- MODE  in  1  0 = generate, 1 = check; sampled with the first word of each frame.
- OUT_VALID  out  1  result available.
- OUT_READY  in  1  consumer takes the result.
- OUT_SUM  out  WIDTH  final checksum.
- OUT_PARITY  out  1  XOR-reduction of OUT_SUM.
- OUT_ERR  out  1  check mode only: high when OUT_SUM != 0; always 0 in generate mode.
- OUT_OVF  out  1  frame exceeded MAX_WORDS.
- OUT_COUNT  out  CW  words accepted, saturating at MAX_WORDS.

## Operation
- States:
  - IDLE: no frame open.
  - ACCUM: frame open, at least one word taken, no LAST yet.
  - HOLD: result presented.
- IN_READY = 1 in IDLE and ACCUM; 0 in HOLD.
- Accept = IN_VALID & IN_READY. Data is ignored when there is no accept.
- Accept in IDLE:
  - acc <= INIT ^ IN_DATA; count <= 1; ovf <= 0; mode latched from MODE.
  - If IN_LAST: go to HOLD. Otherwise go to ACCUM.
- Accept in ACCUM:
  - acc <= acc ^ IN_DATA.
  - If count == MAX_WORDS: set ovf. Otherwise count++.
  - If IN_LAST: go to HOLD.
- Entry to HOLD loads the OUT_* registers from the final acc (including the last word), count, ovf and the latched mode. OUT_VALID = 1.
- HOLD: all OUT_* are held stable until OUT_VALID & OUT_READY. On that handshake, go to IDLE and clear OUT_VALID.
- An overflowed frame still accumulates every word until LAST. OUT_OVF = 1 and OUT_COUNT = MAX_WORDS for such a frame.
- Check-mode identity: the XOR over the data plus an appended generate-mode checksum yields 0 when INIT is the same on both ends.
- OUT_SUM, OUT_PARITY, OUT_ERR, OUT_OVF and OUT_COUNT keep their last values outside HOLD. They are defined only while OUT_VALID = 1.

## Timing
- Reset (async assert, synchronous release): state IDLE, acc 0, count 0.
  - Reset values: OUT_VALID 0, OUT_SUM 0, OUT_PARITY 0, OUT_ERR 0, OUT_OVF 0, OUT_COUNT 0.
  - IN_READY = 1 in the first cycle after release.
- Reset mid-frame discards the partial frame with no residue in acc or count.
- Latency: LAST accepted at edge k gives OUT_VALID = 1 from edge k onward, i.e. visible in cycle k+1.
- Throughput: one word per cycle inside a frame.
- Each frame costs at least one HOLD cycle, during which IN_READY = 0.
- If OUT_READY is held at 1, the next frame's first word is accepted one cycle after OUT_VALID rises.
- A single-word frame (IN_LAST with the first word) is legal and goes IDLE -> HOLD directly.
- IN_VALID with IN_READY = 0 has no effect; the source must hold the word until it is accepted.
- All outputs are registered except IN_READY, which is decoded from state only.

## Structure
- Shared package xor_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_HOLD = 2'd2;
  - MODE_GEN = 1'b0 and MODE_CHECK = 1'b1.
- One sub-module: xor_reduce (parameter WIDTH; input WIDTH-bit word, output 1-bit parity). It is purely combinational and computes OUT_PARITY at HOLD entry.
- Everything else lives in one always block for state/acc/count plus one for the output registers.

## Test plan
WIDTH=8, INIT=0, MAX_WORDS=4 unless stated.
- Generate, words 0x12, 0x34, 0x56 (LAST on 0x56) -> OUT_SUM 0x70, OUT_PARITY 1, OUT_COUNT 3, OUT_ERR 0, OUT_OVF 0. OUT_VALID rises the cycle after LAST.
- Check, words 0x12, 0x34, 0x56, 0x70 -> OUT_SUM 0x00, OUT_ERR 0. Repeat with 0x71 as the last word -> OUT_SUM 0x01, OUT_ERR 1, OUT_PARITY 1.
- Single word 0xA5 with LAST and OUT_READY low for 5 cycles:
  - OUT_VALID 1 and IN_READY 0 throughout; OUT_SUM 0xA5 stable;
  - IN_VALID with 0xFF is ignored;
  - OUT_READY high -> IDLE on the next edge.
- Overflow, six words of 0x01 with LAST on the 6th -> OUT_COUNT 4, OUT_OVF 1, OUT_SUM 0x00.
- Reset asserted mid-frame after 0x11, 0x22 -> all outputs 0 immediately. After release, frame 0xFF (LAST) -> OUT_SUM 0xFF, OUT_COUNT 1. With INIT=0x5A, the same frame -> 0xA5.
- Back-to-back 2-word frames, IN_VALID and OUT_READY held high -> exactly one IN_READY = 0 cycle between frames; each result is correct.
